// File: rtl/pulse_recover.sv
// Capture end of a pulse-stretcher link: synchronizes a wide pulse, measures it,
// and turns each accepted pulse into one dout strobe (rejects into one err strobe).
module pulse_recover #(
    parameter int SYNC_EN = 1,
    parameter int MIN_W   = 4,
    parameter int MAX_W   = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             dout,
    output logic             err,
    output logic [CNT_W-1:0] width,
    output logic             busy
);

    localparam int S = (SYNC_EN != 0) ? 2 : 1;

    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] OVER_C = CNT_W'(MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HIGH     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             dout_q, dout_d;
    logic             err_q, err_d;
    logic [S-1:0]     sync_p0;
    logic             din_q;

    // Input stage: S flops; the FSM only ever looks at the last one.
    generate
        if (S == 2) begin : g_sync2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_p0 <= '0;
                end else begin
                    sync_p0 <= {sync_p0[0], din};
                end
            end
        end else begin : g_sync1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_p0 <= '0;
                end else begin
                    sync_p0 <= din;
                end
            end
        end
    endgenerate

    assign din_q = sync_p0[S-1];

    // Measurement stage: state, counter and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            width_q <= '0;
            dout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        dout_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (din_q) begin
                    state_d = HIGH;
                    cnt_d   = ONE_C;
                end
            end
            HIGH: begin
                if (din_q) begin
                    // Reaching MAX_W+1 high samples is a stuck line; reject now
                    // rather than keep counting, so cnt can never wrap.
                    if (cnt_q == MAX_C) begin
                        err_d   = 1'b1;
                        width_d = OVER_C;
                        state_d = WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    if ((cnt_q >= MIN_C) && (cnt_q <= MAX_C)) begin
                        dout_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    width_d = cnt_q;
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!din_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout  = dout_q;
    assign err   = err_q;
    assign width = width_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_recover.sv
// Bench for pulse_recover: pulse table, directed reset/back-to-back sequences and
// random pulse trains checked against a pulse-level reference model.
module tb_pulse_recover;

    localparam int S      = 2;
    localparam int MIN_W  = 4;
    localparam int MAX_W  = 16;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             dout;
    logic             err;
    logic [CNT_W-1:0] width;
    logic             busy;

    pulse_recover #(.SYNC_EN(1), .MIN_W(MIN_W), .MAX_W(MAX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .err(err), .width(width), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int kind;   // 1 = dout expected, 2 = err expected
        int w;
    } vec_t;

    vec_t vecs[10];

    int n_vec = 0;
    int n_bad = 0;
    int e = 0;
    int rst_e = 0;

    // Reference model: runs of high samples on din, scheduled strobe per run.
    bit hist[DEPTH];
    int ev_kind[DEPTH];
    int ev_w[DEPTH];
    bit in_run = 0;
    bit flagged = 0;
    int run_len = 0;
    int width_exp = 0;

    int obs_dout = 0;
    int obs_err = 0;
    int last_dout_e = 0;
    int last_err_e = 0;
    bit busy_rec[DEPTH];

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", name, e, got, want);
        end
    endtask

    function automatic void sched(input int at, input int kind, input int w);
        if (at < DEPTH) begin
            ev_kind[at] = kind;
            ev_w[at] = w;
        end
    endfunction

    function automatic void model_edge(input bit d);
        hist[e] = d;
        if (d) begin
            if (!in_run) begin
                in_run = 1;
                run_len = 1;
            end else begin
                run_len++;
            end
            if (run_len == MAX_W + 1 && !flagged) begin
                sched(e + S, 2, MAX_W + 1);
                flagged = 1;
            end
        end else if (in_run) begin
            if (!flagged) sched(e + S, (run_len >= MIN_W) ? 1 : 2, run_len);
            in_run = 0;
            flagged = 0;
        end
    endfunction

    function automatic void model_reset();
        in_run = 0;
        flagged = 0;
        run_len = 0;
        width_exp = 0;
        rst_e = e;
        for (int i = e + 1; i < e + S + 4 && i < DEPTH; i++) ev_kind[i] = 0;
    endfunction

    task automatic check_outputs();
        int bexp;
        if (ev_kind[e] != 0) width_exp = ev_w[e];
        bexp = (e - S > rst_e) ? int'(hist[e - S]) : 0;
        chk("dout", int'(dout), (ev_kind[e] == 1) ? 1 : 0);
        chk("err", int'(err), (ev_kind[e] == 2) ? 1 : 0);
        chk("width", int'(width), width_exp);
        chk("busy", int'(busy), bexp);
        busy_rec[e] = busy;
        if (dout) begin obs_dout++; last_dout_e = e; end
        if (err)  begin obs_err++;  last_err_e  = e; end
    endtask

    task automatic step(input bit d);
        @(negedge clk);
        din = d;
        @(posedge clk);
        e++;
        model_edge(d);
        #1;
        check_outputs();
    endtask

    task automatic tick_in_reset();
        @(posedge clk);
        e++;
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_width", int'(width), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    initial begin
        int k;
        int first_dout;
        int zeros;
        int rises;

        vecs[0] = '{hi: 4,  lo: 6, kind: 1, w: 4};
        vecs[1] = '{hi: 1,  lo: 6, kind: 2, w: 1};
        vecs[2] = '{hi: 3,  lo: 6, kind: 2, w: 3};
        vecs[3] = '{hi: 16, lo: 6, kind: 1, w: 16};
        vecs[4] = '{hi: 17, lo: 6, kind: 2, w: 17};
        vecs[5] = '{hi: 25, lo: 6, kind: 2, w: 17};
        vecs[6] = '{hi: 5,  lo: 6, kind: 1, w: 5};
        vecs[7] = '{hi: 2,  lo: 6, kind: 2, w: 2};
        vecs[8] = '{hi: 15, lo: 6, kind: 1, w: 15};
        vecs[9] = '{hi: 4,  lo: 6, kind: 1, w: 4};

        // Reset state
        #12;
        chk("init_dout", int'(dout), 0);
        chk("init_err", int'(err), 0);
        chk("init_width", int'(width), 0);
        chk("init_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        rst_e = 0;
        for (int i = 0; i < 3; i++) step(1'b0);

        // Pulse table
        for (int v = 0; v < 10; v++) begin
            obs_dout = 0;
            obs_err = 0;
            k = e + 1;
            pulse(vecs[v].hi, vecs[v].lo);
            chk($sformatf("vec%0d_douts", v), obs_dout, (vecs[v].kind == 1) ? 1 : 0);
            chk($sformatf("vec%0d_errs", v), obs_err, (vecs[v].kind == 2) ? 1 : 0);
            chk($sformatf("vec%0d_width", v), int'(width), vecs[v].w);
            if (vecs[v].kind == 1)
                chk($sformatf("vec%0d_dout_edge", v), last_dout_e - k, vecs[v].hi + S);
            else
                chk($sformatf("vec%0d_err_edge", v), last_err_e - k,
                    ((vecs[v].hi > MAX_W) ? MAX_W : vecs[v].hi) + S);
        end

        // Back-to-back: two 4-cycle pulses separated by one low sample
        obs_dout = 0;
        obs_err = 0;
        k = e + 1;
        pulse(4, 1);
        first_dout = -1;
        pulse(4, 7);
        chk("b2b_douts", obs_dout, 2);
        chk("b2b_errs", obs_err, 0);
        chk("b2b_width", int'(width), 4);
        chk("b2b_spacing", last_dout_e - (k + 4 + S), 5);
        zeros = 0;
        rises = 0;
        for (int i = k; i < e; i++) begin
            if (busy_rec[i] && !busy_rec[i + 1]) first_dout = i;
            if (first_dout >= 0 && rises == 0 && !busy_rec[i + 1]) zeros++;
            if (first_dout >= 0 && !busy_rec[i] && busy_rec[i + 1]) rises++;
        end
        chk("b2b_busy_gap", zeros, 1);

        // Reset mid-pulse: high cycles 2..3 lost under reset, 7 remain
        step(1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_err", int'(err), 0);
        chk("midrst_width", int'(width), 0);
        chk("midrst_busy", int'(busy), 0);
        tick_in_reset();
        tick_in_reset();
        #2 rst = 1'b0;
        model_reset();
        obs_dout = 0;
        obs_err = 0;
        pulse(7, 6);
        chk("midrst_douts", obs_dout, 1);
        chk("midrst_errs", obs_err, 0);
        chk("midrst_width_after", int'(width), 7);

        // Reset while waiting for a stuck line to fall
        for (int i = 0; i < 22; i++) step(1'b1);
        chk("wl_busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("wlrst_busy", int'(busy), 0);
        chk("wlrst_width", int'(width), 0);
        din = 1'b0;
        tick_in_reset();
        tick_in_reset();
        #2 rst = 1'b0;
        model_reset();
        obs_dout = 0;
        obs_err = 0;
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("wlrst_douts", obs_dout, 0);
        chk("wlrst_errs", obs_err, 0);

        // Random pulse trains against the model
        for (int p = 0; p < 70; p++) begin
            pulse(int'($urandom_range(1, 22)), int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 6; i++) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
